memory_ram_banked: RTL and testbench

- Parametrised byte-addressable data memory with NB byte lanes, each lane a single-port bank.
- Serves unaligned accesses in one cycle through per-lane address increment and lane rotation.
- Adds a valid/ready request handshake, a fixed-latency response channel, optional misalignment faulting, and a clear-on-reset initialisation sequencer.
- Sits between the LSU of the pipelined core and the data address space.

---
 rtl/memory_ram_banked.sv | 144 ++++++++++++++
 tb/tb_memory_ram_banked.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/memory_ram_banked.sv
// Byte-addressable banked data memory: NB single-port byte banks serve unaligned
// accesses in one cycle via per-lane row increment and lane rotation.
module memory_ram_banked #(
  parameter int DEPTH          = 2048,
  parameter int NB             = 4,
  parameter int ALLOW_MISALIGN = 1,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic                     i_wren,
  input  logic [NB-1:0]            i_bmask,
  input  logic [8*NB-1:0]          i_wdata,
  output logic                     o_rsp_valid,
  output logic [8*NB-1:0]          o_rdata,
  output logic                     o_rsp_err,
  output logic                     o_busy
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned ROWS = DEPTH / NB;
  localparam int unsigned RW   = $clog2(ROWS);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [7:0]      r_mem [NB][ROWS];

  logic            w_accept, w_fault;
  logic [OFFW-1:0] w_off;
  logic [RW-1:0]   w_row, w_row_inc;
  logic [RW-1:0]   w_bank_row [NB];
  logic [OFFW-1:0] w_src [NB];
  logic [NB-1:0]   w_bank_we;
  logic [7:0]      w_bank_wd [NB];

  logic            r_v1, r_err1;
  logic [OFFW-1:0] r_off1;
  logic [7:0]      r_rd [NB];
  logic [8*NB-1:0] w_rdata1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_RESET;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    if (r_state == ST_INIT) begin
      w_row_nxt = r_row + 1'b1;
      if (r_row == RW'(ROWS - 1)) w_state_nxt = ST_RUN;
    end
  end

  // Ready is gated by the reset pin so it reads 0 while reset is held, even when
  // the reset state is RUN.
  assign o_req_ready = (r_state == ST_RUN) & i_reset;
  assign o_busy      = (r_state == ST_INIT);
  assign w_accept    = i_req_valid & o_req_ready;

  assign w_off     = i_addr[OFFW-1:0];
  assign w_row     = i_addr[AW-1:OFFW];
  assign w_row_inc = w_row + 1'b1;
  assign w_fault   = (ALLOW_MISALIGN == 0) && (w_off != '0);

  // Lanes below the offset belong to the next row; data/mask rotate left by off.
  always_comb begin
    for (int unsigned k = 0; k < NB; k++) begin
      w_src[k]      = OFFW'(k) - w_off;
      w_bank_row[k] = (OFFW'(k) < w_off) ? w_row_inc : w_row;
      w_bank_we[k]  = w_accept & i_wren & i_bmask[w_src[k]] & ~w_fault;
      w_bank_wd[k]  = i_wdata[8*w_src[k] +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (r_state == ST_INIT)
        r_mem[k][r_row] <= '0;
      else if (w_bank_we[k])
        r_mem[k][w_bank_row[k]] <= w_bank_wd[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_v1   <= 1'b0;
      r_err1 <= 1'b0;
      r_off1 <= '0;
      for (int unsigned k = 0; k < NB; k++) r_rd[k] <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_err1 <= w_fault;
        r_off1 <= w_off;
        for (int unsigned k = 0; k < NB; k++)
          r_rd[k] <= (i_wren | w_fault) ? '0 : r_mem[k][w_bank_row[k]];
      end
    end
  end

  always_comb begin
    w_rdata1 = '0;
    for (int unsigned j = 0; j < NB; j++)
      w_rdata1[8*j +: 8] = r_rd[OFFW'(j) + r_off1];
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic            r_v2, r_err2;
    logic [8*NB-1:0] r_rdata2;
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_v2     <= 1'b0;
        r_err2   <= 1'b0;
        r_rdata2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_err2   <= r_err1;
          r_rdata2 <= w_rdata1;
        end
      end
    end
    assign o_rsp_valid = r_v2;
    assign o_rsp_err   = r_v2 & r_err2;
    assign o_rdata     = r_rdata2;
  end else begin : g_lat1
    assign o_rsp_valid = r_v1;
    assign o_rsp_err   = r_v1 & r_err1;
    assign o_rdata     = w_rdata1;
  end
endmodule

// File: tb/tb_memory_ram_banked.sv
// Directed bench: dut_a (misalign allowed, latency 1) and dut_b (misalign faults,
// latency 2), both DEPTH=64, NB=4 with clear-on-reset.
module tb_memory_ram_banked;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        rst_a, va, ra, wren_a, rv_a, err_a, busy_a;
  logic [5:0]  addr_a;
  logic [3:0]  bm_a;
  logic [31:0] wd_a, rd_a;
  logic        rst_b, vb, rb, wren_b, rv_b, err_b, busy_b;
  logic [5:0]  addr_b;
  logic [3:0]  bm_b;
  logic [31:0] wd_b, rd_b;

  memory_ram_banked #(.DEPTH(64), .NB(4), .ALLOW_MISALIGN(1), .READ_LATENCY(1),
                      .CLEAR_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_req_valid(va), .o_req_ready(ra),
    .i_addr(addr_a), .i_wren(wren_a), .i_bmask(bm_a), .i_wdata(wd_a),
    .o_rsp_valid(rv_a), .o_rdata(rd_a), .o_rsp_err(err_a), .o_busy(busy_a));

  memory_ram_banked #(.DEPTH(64), .NB(4), .ALLOW_MISALIGN(0), .READ_LATENCY(2),
                      .CLEAR_ON_RESET(1)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_req_valid(vb), .o_req_ready(rb),
    .i_addr(addr_b), .i_wren(wren_b), .i_bmask(bm_b), .i_wdata(wd_b),
    .o_rsp_valid(rv_b), .o_rdata(rd_b), .o_rsp_err(err_b), .o_busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic w, input logic [5:0] a, input logic [3:0] m,
                         input logic [31:0] d);
    va = 1'b1; wren_a = w; addr_a = a; bm_a = m; wd_a = d;
  endtask

  task automatic drive_b(input logic w, input logic [5:0] a, input logic [3:0] m,
                         input logic [31:0] d);
    vb = 1'b1; wren_b = w; addr_b = a; bm_b = m; wd_b = d;
  endtask

  task automatic xact_a(input string tag, input logic w, input logic [5:0] a,
                        input logic [3:0] m, input logic [31:0] d, input logic [31:0] exp);
    drive_a(w, a, m, d);
    step();
    va = 1'b0; wren_a = 1'b0; bm_a = '0;
    chk({tag, "_valid"}, rv_a, 1);
    chk({tag, "_data"}, rd_a, exp);
    chk({tag, "_err"}, err_a, 0);
  endtask

  task automatic xact_b(input string tag, input logic w, input logic [5:0] a,
                        input logic [3:0] m, input logic [31:0] d, input logic [31:0] exp,
                        input logic experr);
    drive_b(w, a, m, d);
    step();
    vb = 1'b0; wren_b = 1'b0; bm_b = '0;
    chk({tag, "_early"}, rv_b, 0);
    step();
    chk({tag, "_valid"}, rv_b, 1);
    chk({tag, "_data"}, rd_b, exp);
    chk({tag, "_err"}, err_b, {31'b0, experr});
  endtask

  initial begin
    int na, nb;
    logic bad_ready, saw_valid;
    rst_a = 1'b0; rst_b = 1'b0;
    va = 0; wren_a = 0; addr_a = '0; bm_a = '0; wd_a = '0;
    vb = 0; wren_b = 0; addr_b = '0; bm_b = '0; wd_b = '0;
    step(); step();

    chk("rst_ready", ra, 0);
    chk("rst_busy", busy_a, 1);
    chk("rst_valid", rv_a, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy_b", busy_b, 1);

    rst_a = 1'b1; rst_b = 1'b1;
    chk("init_start_busy", busy_a, 1);
    na = 0; nb = 0; bad_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy_a && ra) bad_ready = 1'b1;
      step();
      if (!busy_a && na == 0) na = i;
      if (!busy_b && nb == 0) nb = i;
    end
    chk("init_cycles_a", na, 16);
    chk("init_cycles_b", nb, 16);
    chk("init_ready_low", bad_ready, 0);
    chk("run_ready", ra, 1);

    xact_a("rd10", 0, 6'h10, 4'hF, 0, 32'h0000_0000);
    xact_a("wr05", 1, 6'h05, 4'hF, 32'hDDCC_BBAA, 32'h0);
    xact_a("rd04", 0, 6'h04, 4'hF, 0, 32'hCCBB_AA00);
    xact_a("rd08", 0, 6'h08, 4'hF, 0, 32'h0000_00DD);
    step();
    chk("idle_valid", rv_a, 0);

    drive_a(1, 6'h00, 4'hF, 32'h1122_3344);
    step();
    chk("b2b_wr_valid", rv_a, 1);
    chk("b2b_wr_data", rd_a, 0);
    drive_a(0, 6'h00, 4'hF, 0);
    step();
    va = 1'b0;
    chk("b2b_rd_valid", rv_a, 1);
    chk("b2b_rd_data", rd_a, 32'h1122_3344);

    xact_a("wr3e", 1, 6'h3E, 4'hF, 32'hA1B2_C3D4, 32'h0);
    xact_a("rd3c", 0, 6'h3C, 4'hF, 0, 32'hC3D4_0000);
    xact_a("rd00", 0, 6'h00, 4'hF, 0, 32'h1122_A1B2);
    xact_a("wr09_m0", 1, 6'h09, 4'h0, 32'hFFFF_FFFF, 32'h0);
    xact_a("rd08_again", 0, 6'h08, 4'hF, 0, 32'h0000_00DD);
    xact_a("wr21_m5", 1, 6'h21, 4'h5, 32'h5566_7788, 32'h0);
    xact_a("rd20", 0, 6'h20, 4'hF, 0, 32'h6600_8800);

    xact_b("b_wr00", 1, 6'h00, 4'hF, 32'h1122_3344, 32'h0, 0);
    xact_b("b_wr01", 1, 6'h01, 4'hF, 32'hAABB_CCDD, 32'h0, 1);
    xact_b("b_rd00", 0, 6'h00, 4'hF, 0, 32'h1122_3344, 0);
    xact_b("b_rd02", 0, 6'h02, 4'hF, 0, 32'h0, 1);

    drive_b(0, 6'h00, 4'hF, 0);
    step();
    vb = 1'b0;
    rst_b = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rv_b) saw_valid = 1'b1;
      step();
    end
    if (rv_b) saw_valid = 1'b1;
    chk("b_rst_no_rsp", saw_valid, 0);
    chk("b_rst_ready", rb, 0);
    rst_b = 1'b1;
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!busy_b && nb == 0) nb = i;
    end
    chk("b_reinit_cycles", nb, 16);
    xact_b("b_rd00_clr", 0, 6'h00, 4'hF, 0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
